// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard frame receiver: synchronises and deglitches PS2C/PS2D, deserialises 11-bit frames, checks them.
// Optional macro BREAK_FILTER_EN: drop F0 (break) prefixes with their following byte, and E0 prefixes.
module ps2_scan_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [7:0] DATO,
  output logic       flag,
  output logic       ERR,
  output logic       BUSY
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] EMIT  = 2'd3;

  localparam int            TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic                  fall;
  logic                  data_bit;

  logic [1:0]    state;
  logic [3:0]    bitcnt;
  logic [TW-1:0] to_cnt;
  logic [9:0]    frame;
  logic          frame_good;
  logic          forward;
  logic          timeout;
  logic          err_set;

  // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      c_sync   <= '1;
      d_sync   <= '1;
      filt_sr  <= '1;
      filt_clk <= 1'b1;
    end else begin
      c_sync  <= {c_sync[0], PS2C};
      d_sync  <= {d_sync[0], PS2D};
      filt_sr <= {filt_sr[FILTER_LEN-2:0], c_sync[1]};
      if (&filt_sr)
        filt_clk <= 1'b1;
      else if (~|filt_sr)
        filt_clk <= 1'b0;
    end
  end

  assign fall       = filt_clk & ~|filt_sr;
  assign data_bit   = d_sync[1];
  assign frame_good = (^frame[8:0]) & frame[9];
  assign timeout    = (state == SHIFT) && !fall && (to_cnt == TO_LAST);
  assign err_set    = timeout || ((state == CHECK) && !frame_good);
  assign BUSY       = (state != IDLE);

`ifdef BREAK_FILTER_EN
  logic break_pend;

  assign forward = frame_good && (frame[7:0] != 8'hE0) && (frame[7:0] != 8'hF0) && !break_pend;

  always_ff @(posedge CLK) begin
    if (RESET || err_set)
      break_pend <= 1'b0;
    else if ((state == CHECK) && frame_good && (frame[7:0] != 8'hE0))
      break_pend <= (frame[7:0] == 8'hF0);
  end
`else
  assign forward = frame_good;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      bitcnt <= '0;
      to_cnt <= '0;
      frame  <= '0;
      DATO   <= 8'h00;
      flag   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      ERR <= err_set;
      // flag follows EMIT by one edge so DATO (loaded leaving CHECK) is stable a full cycle before flag rises.
      flag <= (state == EMIT);
      case (state)
        IDLE: begin
          if (fall && !data_bit) begin
            state  <= SHIFT;
            bitcnt <= '0;
            to_cnt <= '0;
          end
        end
        SHIFT: begin
          if (fall) begin
            frame  <= {data_bit, frame[9:1]};
            to_cnt <= '0;
            if (bitcnt == 4'd9)
              state <= CHECK;
            else
              bitcnt <= bitcnt + 4'd1;
          end else if (timeout) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (forward) begin
            DATO  <= frame[7:0];
            state <= EMIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: directed scenarios, then random frames against a byte-level model.
// Build with +define+BREAK_FILTER_EN to check the break-filtering variant.
module tb_ps2_scan_rx;

  localparam int TO   = 300;
  localparam int HALF = 40;
  localparam int GAP  = 60;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       PS2C = 1'b1;
  logic       PS2D = 1'b1;
  logic [7:0] DATO;
  logic       flag;
  logic       ERR;
  logic       BUSY;

  int vectors = 0;
  int miscompares = 0;
  int flag_cnt = 0;
  int err_cnt = 0;
  logic [7:0] dato_at_flag = 8'h00;
  logic [7:0] dato_prev = 8'h00;
  bit         busy_seen = 1'b0;

  logic [7:0] m_dato = 8'h00;
  bit         m_break = 1'b0;

  ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TO)) dut (
    .CLK  (clk),
    .RESET(RESET),
    .PS2C (PS2C),
    .PS2D (PS2D),
    .DATO (DATO),
    .flag (flag),
    .ERR  (ERR),
    .BUSY (BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!RESET) begin
      if (flag) begin
        flag_cnt++;
        dato_at_flag = DATO;
        check("dato_lead", {24'b0, DATO}, {24'b0, dato_prev});
      end
      if (ERR) err_cnt++;
      if (flag || ERR) check("flag_err_excl", {31'b0, flag & ERR}, 32'd0);
      if (BUSY) busy_seen = 1'b1;
    end
    dato_prev = DATO;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    PS2D = b;
    wait_cyc(HALF / 2);
    PS2C = 1'b0;
    wait_cyc(HALF);
    PS2C = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    PS2D = 1'b1;
    wait_cyc(GAP);
  endtask

  // Model: a byte is good when data+parity has odd weight and stop is 1; break filter decides forwarding.
  task automatic send_and_check(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int f0;
    int e0;
    bit good;
    bit fwd;
    f0 = flag_cnt;
    e0 = err_cnt;
    good = !bad_par && !bad_stop;
    send_frame(b, bad_par, bad_stop);
    fwd = 1'b0;
    if (!good) begin
      m_break = 1'b0;
    end else begin
`ifdef BREAK_FILTER_EN
      if (b == 8'hF0) m_break = 1'b1;
      else if (b != 8'hE0) begin
        fwd = !m_break;
        m_break = 1'b0;
      end
`else
      fwd = 1'b1;
`endif
    end
    if (fwd) m_dato = b;
    check({tag, "_flag"}, flag_cnt - f0, {31'b0, fwd});
    check({tag, "_err"}, err_cnt - e0, {31'b0, !good});
    check({tag, "_dato"}, {24'b0, DATO}, {24'b0, m_dato});
    check({tag, "_busy"}, {31'b0, BUSY}, 32'd0);
    if (fwd) check({tag, "_dato_at_flag"}, {24'b0, dato_at_flag}, {24'b0, b});
  endtask

  initial begin
    int f0;
    int e0;
    logic [7:0] b;
    bit bp;
    bit bs;

    wait_cyc(4);
    check("rst_dato", {24'b0, DATO}, 32'd0);
    check("rst_flag", {31'b0, flag}, 32'd0);
    check("rst_err", {31'b0, ERR}, 32'd0);
    check("rst_busy", {31'b0, BUSY}, 32'd0);
    RESET = 1'b0;
    wait_cyc(20);

    // T1 / T2: good 0x5A, then 0x1C with wrong parity
    send_and_check("t1_5a", 8'h5A, 1'b0, 1'b0);
    send_and_check("t2_1c_badpar", 8'h1C, 1'b1, 1'b0);
    send_and_check("stop_bad", 8'h33, 1'b0, 1'b1);

    // T3: start + 5 bits, then clock stays high past the timeout
    f0 = flag_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    PS2D = 1'b1;
    check("t3_busy_mid", {31'b0, BUSY}, 32'd1);
    wait_cyc(TO + 50);
    m_break = 1'b0;
    check("t3_err", err_cnt - e0, 32'd1);
    check("t3_flag", flag_cnt - f0, 32'd0);
    check("t3_busy_after", {31'b0, BUSY}, 32'd0);
    check("t3_dato", {24'b0, DATO}, {24'b0, m_dato});
    send_and_check("t3_4d", 8'h4D, 1'b0, 1'b0);

    // T4: 3-cycle low glitch on PS2C while idle
    f0 = flag_cnt;
    e0 = err_cnt;
    busy_seen = 1'b0;
    PS2C = 1'b0;
    wait_cyc(3);
    PS2C = 1'b1;
    wait_cyc(30);
    check("t4_busy", {31'b0, busy_seen}, 32'd0);
    check("t4_events", (flag_cnt - f0) + (err_cnt - e0), 32'd0);

    // T5: F0 4D 4D
    f0 = flag_cnt;
    send_and_check("t5_f0", 8'hF0, 1'b0, 1'b0);
    send_and_check("t5_4d_a", 8'h4D, 1'b0, 1'b0);
    send_and_check("t5_4d_b", 8'h4D, 1'b0, 1'b0);
`ifdef BREAK_FILTER_EN
    check("t5_flags", flag_cnt - f0, 32'd1);
`else
    check("t5_flags", flag_cnt - f0, 32'd3);
`endif
    send_and_check("e0_prefix", 8'hE0, 1'b0, 1'b0);

    // T6: reset pulse after the 4th data bit
    f0 = flag_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    PS2D = 1'b1;
    RESET = 1'b1;
    wait_cyc(1);
    RESET = 1'b0;
    check("t6_dato", {24'b0, DATO}, 32'd0);
    check("t6_busy", {31'b0, BUSY}, 32'd0);
    wait_cyc(30);
    check("t6_events", (flag_cnt - f0) + (err_cnt - e0), 32'd0);
    m_dato = 8'h00;
    m_break = 1'b0;
    send_and_check("t6_34", 8'h34, 1'b0, 1'b0);

    // Random frames, biased toward prefix bytes and occasional corruption
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 7))
        0: b = 8'hF0;
        1: b = 8'hE0;
        default: b = 8'($urandom);
      endcase
      bp = ($urandom_range(0, 5) == 0);
      bs = ($urandom_range(0, 7) == 0);
      send_and_check($sformatf("rnd%0d", n), b, bp, bs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
